// File: rtl/memory_arbiter.sv
// Two-client arbiter in front of a single memory: independent write and read arbitration,
// read responses steered by a one-deep tag. Define MEMORY_ARBITER_RR_EN for round-robin priority.
module memory_arbiter #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c0_waddr_stb,
  input  logic [AW-1:0]    c0_waddr_dat,
  output logic             c0_waddr_rdy,
  input  logic             c0_wdata_stb,
  input  logic [WIDTH-1:0] c0_wdata_dat,
  output logic             c0_wdata_rdy,
  input  logic             c0_raddr_stb,
  input  logic [AW-1:0]    c0_raddr_dat,
  output logic             c0_raddr_rdy,
  output logic             c0_rdata_stb,
  output logic [WIDTH-1:0] c0_rdata_dat,
  input  logic             c0_rdata_rdy,
  input  logic             c1_waddr_stb,
  input  logic [AW-1:0]    c1_waddr_dat,
  output logic             c1_waddr_rdy,
  input  logic             c1_wdata_stb,
  input  logic [WIDTH-1:0] c1_wdata_dat,
  output logic             c1_wdata_rdy,
  input  logic             c1_raddr_stb,
  input  logic [AW-1:0]    c1_raddr_dat,
  output logic             c1_raddr_rdy,
  output logic             c1_rdata_stb,
  output logic [WIDTH-1:0] c1_rdata_dat,
  input  logic             c1_rdata_rdy,
  output logic             m_waddr_stb,
  output logic [AW-1:0]    m_waddr_dat,
  input  logic             m_waddr_rdy,
  output logic             m_wdata_stb,
  output logic [WIDTH-1:0] m_wdata_dat,
  input  logic             m_wdata_rdy,
  output logic             m_raddr_stb,
  output logic [AW-1:0]    m_raddr_dat,
  input  logic             m_raddr_rdy,
  input  logic             m_rdata_stb,
  input  logic [WIDTH-1:0] m_rdata_dat,
  output logic             m_rdata_rdy
);

  logic tag_vld_q, tag_vld_d;
  logic tag_id_q, tag_id_d;
  logic wr_ptr_q, wr_ptr_d;
  logic rd_ptr_q, rd_ptr_d;

  logic wr_elig0_s, wr_elig1_s, wr_gnt_s;
  logic rd_gnt_s, rsp_pop_s, issue_ok_s, rd_xfer_s;
  logic unused_wdata_rdy_s;

  // Memory write-data ready is implied by write-address ready for this memory.
  assign unused_wdata_rdy_s = m_wdata_rdy;

  // Write arbitration: a client competes only with both of its write strobes high.
  always_comb begin
    wr_elig0_s = c0_waddr_stb & c0_wdata_stb;
    wr_elig1_s = c1_waddr_stb & c1_wdata_stb;
    if (wr_elig0_s & wr_elig1_s) begin
      wr_gnt_s = wr_ptr_q;
    end else if (wr_elig1_s) begin
      wr_gnt_s = 1'b1;
    end else begin
      wr_gnt_s = 1'b0;
    end
    m_waddr_stb  = wr_elig0_s | wr_elig1_s;
    m_wdata_stb  = wr_elig0_s | wr_elig1_s;
    m_waddr_dat  = wr_gnt_s ? c1_waddr_dat : c0_waddr_dat;
    m_wdata_dat  = wr_gnt_s ? c1_wdata_dat : c0_wdata_dat;
    c0_waddr_rdy = wr_elig0_s & ~wr_gnt_s & m_waddr_rdy;
    c0_wdata_rdy = wr_elig0_s & ~wr_gnt_s & m_waddr_rdy;
    c1_waddr_rdy = wr_elig1_s & wr_gnt_s & m_waddr_rdy;
    c1_wdata_rdy = wr_elig1_s & wr_gnt_s & m_waddr_rdy;
  end

  // Read arbitration and response steering; a new read issues only once the tag is free.
  always_comb begin
    if (c0_raddr_stb & c1_raddr_stb) begin
      rd_gnt_s = rd_ptr_q;
    end else if (c1_raddr_stb) begin
      rd_gnt_s = 1'b1;
    end else begin
      rd_gnt_s = 1'b0;
    end
    m_rdata_rdy  = tag_vld_q ? (tag_id_q ? c1_rdata_rdy : c0_rdata_rdy) : 1'b1;
    rsp_pop_s    = m_rdata_stb & m_rdata_rdy;
    issue_ok_s   = ~tag_vld_q | rsp_pop_s;
    m_raddr_stb  = (c0_raddr_stb | c1_raddr_stb) & issue_ok_s;
    m_raddr_dat  = rd_gnt_s ? c1_raddr_dat : c0_raddr_dat;
    rd_xfer_s    = m_raddr_stb & m_raddr_rdy;
    c0_raddr_rdy = c0_raddr_stb & ~rd_gnt_s & m_raddr_rdy & issue_ok_s;
    c1_raddr_rdy = c1_raddr_stb & rd_gnt_s & m_raddr_rdy & issue_ok_s;
    c0_rdata_stb = m_rdata_stb & tag_vld_q & ~tag_id_q;
    c1_rdata_stb = m_rdata_stb & tag_vld_q & tag_id_q;
    c0_rdata_dat = m_rdata_dat;
    c1_rdata_dat = m_rdata_dat;
  end

  // Tag and priority-pointer next state; an untagged beat (orphan) leaves the tag clear.
  always_comb begin
    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    if (rd_xfer_s) begin
      tag_vld_d = 1'b1;
      tag_id_d  = rd_gnt_s;
    end else if (rsp_pop_s) begin
      tag_vld_d = 1'b0;
    end else begin
      tag_vld_d = tag_vld_q;
    end
`ifdef MEMORY_ARBITER_RR_EN
    wr_ptr_d = (m_waddr_stb & m_waddr_rdy) ? ~wr_gnt_s : wr_ptr_q;
    rd_ptr_d = rd_xfer_s ? ~rd_gnt_s : rd_ptr_q;
`else
    wr_ptr_d = 1'b0;
    rd_ptr_d = 1'b0;
`endif
  end

  // State registers; reset overrides any transfer on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= 1'b0;
      tag_id_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: behavioural memory, directed stimulus and a
// per-client response scoreboard. Expectations follow MEMORY_ARBITER_RR_EN when defined.
module tb_memory_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
`ifdef MEMORY_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic c0_waddr_stb, c0_waddr_rdy, c0_wdata_stb, c0_wdata_rdy;
  logic c0_raddr_stb, c0_raddr_rdy, c0_rdata_stb, c0_rdata_rdy;
  logic c1_waddr_stb, c1_waddr_rdy, c1_wdata_stb, c1_wdata_rdy;
  logic c1_raddr_stb, c1_raddr_rdy, c1_rdata_stb, c1_rdata_rdy;
  logic [AW-1:0]    c0_waddr_dat, c0_raddr_dat, c1_waddr_dat, c1_raddr_dat;
  logic [WIDTH-1:0] c0_wdata_dat, c0_rdata_dat, c1_wdata_dat, c1_rdata_dat;
  logic m_waddr_stb, m_waddr_rdy, m_wdata_stb, m_wdata_rdy;
  logic m_raddr_stb, m_raddr_rdy, m_rdata_stb, m_rdata_rdy;
  logic [AW-1:0]    m_waddr_dat, m_raddr_dat;
  logic [WIDTH-1:0] m_wdata_dat, m_rdata_dat;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic             mem_rvld = 1'b0;
  logic [WIDTH-1:0] mem_rdat;
  logic [WIDTH-1:0] exp_q0 [$];
  logic [WIDTH-1:0] exp_q1 [$];

  always #5 clk = ~clk;

  memory_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .c0_waddr_stb(c0_waddr_stb), .c0_waddr_dat(c0_waddr_dat), .c0_waddr_rdy(c0_waddr_rdy),
    .c0_wdata_stb(c0_wdata_stb), .c0_wdata_dat(c0_wdata_dat), .c0_wdata_rdy(c0_wdata_rdy),
    .c0_raddr_stb(c0_raddr_stb), .c0_raddr_dat(c0_raddr_dat), .c0_raddr_rdy(c0_raddr_rdy),
    .c0_rdata_stb(c0_rdata_stb), .c0_rdata_dat(c0_rdata_dat), .c0_rdata_rdy(c0_rdata_rdy),
    .c1_waddr_stb(c1_waddr_stb), .c1_waddr_dat(c1_waddr_dat), .c1_waddr_rdy(c1_waddr_rdy),
    .c1_wdata_stb(c1_wdata_stb), .c1_wdata_dat(c1_wdata_dat), .c1_wdata_rdy(c1_wdata_rdy),
    .c1_raddr_stb(c1_raddr_stb), .c1_raddr_dat(c1_raddr_dat), .c1_raddr_rdy(c1_raddr_rdy),
    .c1_rdata_stb(c1_rdata_stb), .c1_rdata_dat(c1_rdata_dat), .c1_rdata_rdy(c1_rdata_rdy),
    .m_waddr_stb(m_waddr_stb), .m_waddr_dat(m_waddr_dat), .m_waddr_rdy(m_waddr_rdy),
    .m_wdata_stb(m_wdata_stb), .m_wdata_dat(m_wdata_dat), .m_wdata_rdy(m_wdata_rdy),
    .m_raddr_stb(m_raddr_stb), .m_raddr_dat(m_raddr_dat), .m_raddr_rdy(m_raddr_rdy),
    .m_rdata_stb(m_rdata_stb), .m_rdata_dat(m_rdata_dat), .m_rdata_rdy(m_rdata_rdy)
  );

  // Behavioural memory: registered read port, read strobe deliberately not reset.
  always @(posedge clk) begin
    if (m_waddr_stb && m_waddr_rdy) mem[m_waddr_dat] <= m_wdata_dat;
    if (m_raddr_stb && m_raddr_rdy) begin
      mem_rvld <= 1'b1;
      mem_rdat <= mem[m_raddr_dat];
    end else if (mem_rvld && m_rdata_rdy) begin
      mem_rvld <= 1'b0;
    end
  end
  assign m_rdata_stb = mem_rvld;
  assign m_rdata_dat = mem_rdat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop/compare responses, then push read expectations before applying writes.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_d;
    #3;
    if (!rst) begin
      if (c0_rdata_stb && c0_rdata_rdy) begin
        if (exp_q0.size() == 0) check_eq("c0_rsp_unexpected", c0_rdata_stb, 1'b0);
        else begin
          exp_d = exp_q0.pop_front();
          check_eq("c0_rsp_data", c0_rdata_dat, exp_d);
        end
      end
      if (c1_rdata_stb && c1_rdata_rdy) begin
        if (exp_q1.size() == 0) check_eq("c1_rsp_unexpected", c1_rdata_stb, 1'b0);
        else begin
          exp_d = exp_q1.pop_front();
          check_eq("c1_rsp_data", c1_rdata_dat, exp_d);
        end
      end
      if (c0_rdata_stb && c1_rdata_stb) check_eq("rsp_exclusive", c1_rdata_stb, 1'b0);
      if (c0_raddr_stb && c0_raddr_rdy) exp_q0.push_back(ref_mem[c0_raddr_dat]);
      if (c1_raddr_stb && c1_raddr_rdy) exp_q1.push_back(ref_mem[c1_raddr_dat]);
      if (c0_waddr_stb && c0_wdata_stb && c0_waddr_rdy) ref_mem[c0_waddr_dat] = c0_wdata_dat;
      if (c1_waddr_stb && c1_wdata_stb && c1_waddr_rdy) ref_mem[c1_waddr_dat] = c1_wdata_dat;
    end
  end

  initial begin
    int w;
    int g;
    int prev_g;
    rst = 1'b1;
    m_waddr_rdy = 1'b1; m_wdata_rdy = 1'b1; m_raddr_rdy = 1'b1;
    c0_waddr_stb = 1'b0; c0_wdata_stb = 1'b0; c0_raddr_stb = 1'b0; c0_rdata_rdy = 1'b1;
    c1_waddr_stb = 1'b0; c1_wdata_stb = 1'b0; c1_raddr_stb = 1'b0; c1_rdata_rdy = 1'b1;
    c0_waddr_dat = 8'h00; c0_wdata_dat = 16'h0000; c0_raddr_dat = 8'h00;
    c1_waddr_dat = 8'h00; c1_wdata_dat = 16'h0000; c1_raddr_dat = 8'h00;

    // Reset: a read presented during reset leaves a stale beat in the memory, but no tag.
    repeat (2) @(negedge clk);
    c0_raddr_stb = 1'b1;
    #1;
    check_eq("rst_m_rdata_rdy", m_rdata_rdy, 1'b1);
    @(negedge clk);
    rst = 1'b0; c0_raddr_stb = 1'b0;
    #1;
    check_eq("orphan_present", m_rdata_stb, 1'b1);
    check_eq("orphan_rdy", m_rdata_rdy, 1'b1);
    check_eq("orphan_c0_hidden", c0_rdata_stb, 1'b0);
    check_eq("orphan_c1_hidden", c1_rdata_stb, 1'b0);
    @(negedge clk);
    #1;
    check_eq("orphan_consumed", m_rdata_stb, 1'b0);

    // c0 writes 0x10 = 0xBEEF, then c1 reads it back.
    @(negedge clk);
    c0_waddr_stb = 1'b1; c0_waddr_dat = 8'h10; c0_wdata_stb = 1'b1; c0_wdata_dat = 16'hBEEF;
    #1;
    check_eq("wr_c0_waddr_rdy", c0_waddr_rdy, 1'b1);
    check_eq("wr_c0_wdata_rdy", c0_wdata_rdy, 1'b1);
    check_eq("wr_c1_idle_rdy", c1_waddr_rdy, 1'b0);
    check_eq("wr_m_addr", m_waddr_dat, 8'h10);
    check_eq("wr_m_data", m_wdata_dat, 16'hBEEF);
    @(negedge clk);
    c0_waddr_stb = 1'b0; c0_wdata_stb = 1'b0;
    c1_raddr_stb = 1'b1; c1_raddr_dat = 8'h10;
    #1;
    check_eq("rd_c1_raddr_rdy", c1_raddr_rdy, 1'b1);
    @(negedge clk);
    c1_raddr_stb = 1'b0;
    #1;
    check_eq("rd_c1_rsp_stb", c1_rdata_stb, 1'b1);
    check_eq("rd_c1_rsp_dat", c1_rdata_dat, 16'hBEEF);
    check_eq("rd_c0_no_rsp", c0_rdata_stb, 1'b0);
    @(negedge clk);
    #1;
    check_eq("rd_rsp_single", c1_rdata_stb, 1'b0);

    // Both clients write at once: c0 0x01=0x1111, c1 0x02=0x2222.
    w = RR ? 1 : 0;
    c0_waddr_stb = 1'b1; c0_waddr_dat = 8'h01; c0_wdata_stb = 1'b1; c0_wdata_dat = 16'h1111;
    c1_waddr_stb = 1'b1; c1_waddr_dat = 8'h02; c1_wdata_stb = 1'b1; c1_wdata_dat = 16'h2222;
    #1;
    check_eq("wr2_c0_rdy", c0_waddr_rdy, w == 0);
    check_eq("wr2_c1_rdy", c1_waddr_rdy, w == 1);
    check_eq("wr2_m_addr", m_waddr_dat, (w == 1) ? 8'h02 : 8'h01);
    @(negedge clk);
    if (w == 1) begin c1_waddr_stb = 1'b0; c1_wdata_stb = 1'b0; end
    else begin c0_waddr_stb = 1'b0; c0_wdata_stb = 1'b0; end
    #1;
    check_eq("wr2_loser_c0_rdy", c0_waddr_rdy, w == 1);
    check_eq("wr2_loser_c1_rdy", c1_waddr_rdy, w == 0);
    @(negedge clk);
    c0_waddr_stb = 1'b0; c0_wdata_stb = 1'b0; c1_waddr_stb = 1'b0; c1_wdata_stb = 1'b0;

    // Partial request: c0 address only, c1 full write 0x30 = 0x3333.
    c0_waddr_stb = 1'b1; c0_waddr_dat = 8'h20; c0_wdata_dat = 16'h4444;
    c1_waddr_stb = 1'b1; c1_waddr_dat = 8'h30; c1_wdata_stb = 1'b1; c1_wdata_dat = 16'h3333;
    #1;
    check_eq("part_c1_rdy", c1_waddr_rdy, 1'b1);
    check_eq("part_c0_rdy", c0_waddr_rdy, 1'b0);
    @(negedge clk);
    c1_waddr_stb = 1'b0; c1_wdata_stb = 1'b0;
    #1;
    check_eq("part_c0_alone_rdy", c0_waddr_rdy, 1'b0);
    check_eq("part_m_stb", m_waddr_stb, 1'b0);
    @(negedge clk);
    c0_wdata_stb = 1'b1;
    #1;
    check_eq("part_c0_full_rdy", c0_waddr_rdy, 1'b1);
    @(negedge clk);
    c0_waddr_stb = 1'b0; c0_wdata_stb = 1'b0;

    // Both clients read continuously.
    c0_raddr_stb = 1'b1; c0_raddr_dat = 8'h01;
    c1_raddr_stb = 1'b1; c1_raddr_dat = 8'h02;
    prev_g = -1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      g = RR ? (i % 2) : 0;
      #1;
      check_eq("cont_c0_raddr_rdy", c0_raddr_rdy, g == 0);
      check_eq("cont_c1_raddr_rdy", c1_raddr_rdy, g == 1);
      check_eq("cont_c0_rsp", c0_rdata_stb, prev_g == 0);
      check_eq("cont_c1_rsp", c1_rdata_stb, prev_g == 1);
      prev_g = g;
    end
    @(negedge clk);
    c0_raddr_stb = 1'b0; c1_raddr_stb = 1'b0;
    #1;
    check_eq("cont_last_c0_rsp", c0_rdata_stb, prev_g == 0);
    check_eq("cont_last_c1_rsp", c1_rdata_stb, prev_g == 1);
    @(negedge clk);

    // Back-pressure: c0 stalls its response for 5 cycles while c1 waits to read.
    c0_raddr_stb = 1'b1; c0_raddr_dat = 8'h01; c0_rdata_rdy = 1'b0;
    #1;
    check_eq("bp_c0_raddr_rdy", c0_raddr_rdy, 1'b1);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      c0_raddr_stb = 1'b0;
      c1_raddr_stb = 1'b1; c1_raddr_dat = 8'h02;
      c1_waddr_stb = (s == 2); c1_wdata_stb = (s == 2);
      c1_waddr_dat = 8'h40; c1_wdata_dat = 16'h5555;
      #1;
      check_eq("bp_c1_raddr_rdy", c1_raddr_rdy, 1'b0);
      check_eq("bp_c0_rsp_held", c0_rdata_stb, 1'b1);
      check_eq("bp_m_rdata_rdy", m_rdata_rdy, 1'b0);
      if (s == 2) check_eq("bp_write_flows", c1_waddr_rdy, 1'b1);
    end
    @(negedge clk);
    c1_waddr_stb = 1'b0; c1_wdata_stb = 1'b0; c0_rdata_rdy = 1'b1;
    #1;
    check_eq("bp_release_c0_rsp", c0_rdata_stb, 1'b1);
    check_eq("bp_release_c1_rdy", c1_raddr_rdy, 1'b1);
    @(negedge clk);
    c1_raddr_stb = 1'b0;
    #1;
    check_eq("bp_c1_rsp", c1_rdata_stb, 1'b1);
    check_eq("bp_c0_no_rsp", c0_rdata_stb, 1'b0);
    @(negedge clk);

    // Same-address read and write in one cycle returns old contents; then read back.
    c0_raddr_stb = 1'b1; c0_raddr_dat = 8'h10;
    c1_waddr_stb = 1'b1; c1_wdata_stb = 1'b1; c1_waddr_dat = 8'h10; c1_wdata_dat = 16'h7777;
    #1;
    check_eq("raw_c0_raddr_rdy", c0_raddr_rdy, 1'b1);
    check_eq("raw_c1_waddr_rdy", c1_waddr_rdy, 1'b1);
    @(negedge clk);
    c1_waddr_stb = 1'b0; c1_wdata_stb = 1'b0; c0_raddr_dat = 8'h20;
    #1;
    check_eq("raw_old_data", c0_rdata_dat, 16'hBEEF);
    @(negedge clk); c0_raddr_dat = 8'h30;
    @(negedge clk); c0_raddr_dat = 8'h40;
    @(negedge clk); c0_raddr_dat = 8'h10;
    @(negedge clk); c0_raddr_stb = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("q0_drained", exp_q0.size(), 0);
    check_eq("q1_drained", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
